instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues word fetches, tracks in-flight
// responses, drops stale ones after redirects, buffers {pc, instr}.
//
// Ports
//   clk, reset           clock, async active-low reset
//   redirect/_pc         taken branch: flush queue, refetch at target
//   imem_req/addr/gnt    fetch request channel (accept = req & gnt)
//   imem_rvalid/rdata    in-order fetch responses
//   instr_valid/instr/   queue head toward IF/ID register,
//   instr_pc/ready       popped on valid & ready
//   err_spurious         sticky: response seen with nothing in flight
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        err_spurious
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // Outstanding-request counters. Redirects can leave
  // dropped responses outstanding on top of kept ones,
  // so these are wider than the queue occupancy.
  localparam int OW = 8;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] inflight_q, inflight_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic          err_q, err_d;

  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];

  logic [OW-1:0] kept;
  logic [OW:0]   occ;
  logic [31:0]   tgt;
  logic          accept;
  logic          rsp_live;
  logic          spur;
  logic          push;
  logic          pop;
  logic          dropping;

  // Kept in-flight responses will each need a slot,
  // so they count against the queue capacity.
  always_comb begin
    kept = inflight_q - drop_q;
    occ  = {1'b0, kept} + (OW+1)'(count_q);
    tgt  = redirect_pc & 32'hFFFF_FFFC;
  end

  // Outputs are gated by the reset input so nothing
  // is requested or presented while reset is held.
  always_comb begin
    imem_req    = reset & ~redirect
                & (occ < (OW+1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    instr_valid = reset & ~redirect
                & (count_q != '0);
    instr       = ins_mem_q[head_q];
    instr_pc    = pc_mem_q[head_q];
    err_spurious = err_q;
  end

  always_comb begin
    accept   = imem_req & imem_gnt;
    rsp_live = imem_rvalid & (inflight_q != '0);
    spur     = imem_rvalid & (inflight_q == '0);
    dropping = drop_q != '0;
    push     = rsp_live & ~redirect & ~dropping;
    pop      = instr_valid & instr_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + OW'(accept)
               - OW'(rsp_live);
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    err_d      = err_q | spur;

    if (redirect) begin
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      // Everything still outstanding after this
      // cycle's response belongs to the old path.
      drop_d     = inflight_q - OW'(rsp_live);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_live && dropping) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push)
              - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      err_q      <= err_d;
    end
  end

  // Storage is cleared on reset so the head shows
  // zero while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]  <= resp_pc_q;
      ins_mem_q[tail_q] <= imem_rdata;
    end
  end

endmodule
